piezo_note_seq: RTL and testbench

Melody sequencer that sits directly upstream of the piezo tone generator. It walks a fixed song stored in a small note ROM and holds each note for a programmable number of tempo ticks, followed by a silent gap. For every note it presents the half-period divisor (tone_cnt) that the tone generator consumes. It replaces the hard-coded note counter with start/stop/loop control and a clean timing contract.

---
 rtl/piezo_pkg.sv | 36 +++
 rtl/piezo_note_rom.sv | 29 ++
 rtl/piezo_note_seq.sv | 147 ++++++++++++++
 tb/tb_piezo_note_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared constants for the piezo melody sequencer: pitch codes, tone divisors,
// ROM entry layout and the sequencer state encoding.
package piezo_pkg;

    localparam int PITCH_W = 3;
    localparam int DUR_W   = 3;
    localparam int ENTRY_W = PITCH_W + DUR_W;
    localparam int TONE_W  = 10;
    localparam int IDX_W   = 4;

    localparam logic [PITCH_W-1:0] P_REST = 3'd0;
    localparam logic [PITCH_W-1:0] P_C    = 3'd1;
    localparam logic [PITCH_W-1:0] P_D    = 3'd2;
    localparam logic [PITCH_W-1:0] P_E    = 3'd3;
    localparam logic [PITCH_W-1:0] P_F    = 3'd4;
    localparam logic [PITCH_W-1:0] P_G    = 3'd5;
    localparam logic [PITCH_W-1:0] P_A    = 3'd6;
    localparam logic [PITCH_W-1:0] P_B    = 3'd7;

    // Half-period divisors consumed by the downstream tone generator.
    localparam logic [TONE_W-1:0] DIV_C = 10'd956;
    localparam logic [TONE_W-1:0] DIV_D = 10'd851;
    localparam logic [TONE_W-1:0] DIV_E = 10'd758;
    localparam logic [TONE_W-1:0] DIV_F = 10'd716;
    localparam logic [TONE_W-1:0] DIV_G = 10'd638;
    localparam logic [TONE_W-1:0] DIV_A = 10'd568;
    localparam logic [TONE_W-1:0] DIV_B = 10'd506;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/piezo_note_rom.sv
// Fixed song table: index -> {pitch, dur}. Entries at or beyond SONG_LEN read
// back as a one-tick rest.
module piezo_note_rom
    import piezo_pkg::*;
#(
    parameter int SONG_LEN = 8
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    always_comb begin
        entry = {P_REST, 3'd1};
        if (32'(idx) < SONG_LEN) begin
            case (idx)
                4'd0:    entry = {P_G, 3'd2};
                4'd1:    entry = {P_G, 3'd2};
                4'd2:    entry = {P_E, 3'd2};
                4'd3:    entry = {P_D, 3'd2};
                4'd4:    entry = {P_G, 3'd2};
                4'd5:    entry = {P_G, 3'd2};
                4'd6:    entry = {P_E, 3'd4};
                4'd7:    entry = {P_REST, 3'd4};
                default: entry = {P_REST, 3'd1};
            endcase
        end
    end

endmodule

// File: rtl/piezo_note_seq.sv
// Melody sequencer: walks the note ROM, holds each note for dur tempo ticks,
// then a silent gap, and presents the tone divisor to the tone generator.
module piezo_note_seq
    import piezo_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int GAP_TICKS = 1,
    parameter int SONG_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [TONE_W-1:0] tone_cnt,
    output logic              note_valid,
    output logic [IDX_W-1:0]  note_idx,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    state_t              state, state_next;
    logic [TW-1:0]       tick_cnt, tick_d;
    logic [DUR_W-1:0]    dur_cnt, dur_d;
    logic [GW-1:0]       gap_cnt, gap_d;
    logic [TONE_W-1:0]   tone_d;
    logic                valid_d, done_d;
    logic [IDX_W-1:0]    idx_d;
    logic [ENTRY_W-1:0]  rom_entry;
    logic [PITCH_W-1:0]  pitch;
    logic [DUR_W-1:0]    dur;
    logic                tick, play_end, gap_end, advance, last, finish, abort;

    piezo_note_rom #(.SONG_LEN(SONG_LEN)) u_rom (
        .idx   (note_idx),
        .entry (rom_entry)
    );

    assign pitch = rom_entry[ENTRY_W-1:DUR_W];
    assign dur   = rom_entry[DUR_W-1:0];

    function automatic logic [TONE_W-1:0] pitch_div(input logic [PITCH_W-1:0] p);
        case (p)
            P_C:     return DIV_C;
            P_D:     return DIV_D;
            P_E:     return DIV_E;
            P_F:     return DIV_F;
            P_G:     return DIV_G;
            P_A:     return DIV_A;
            P_B:     return DIV_B;
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            tone_cnt   <= '0;
            note_valid <= 1'b0;
            note_idx   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_d;
            dur_cnt    <= dur_d;
            gap_cnt    <= gap_d;
            tone_cnt   <= tone_d;
            note_valid <= valid_d;
            note_idx   <= idx_d;
            done       <= done_d;
        end
    end

    always_comb begin
        tick     = (state == S_PLAY || state == S_GAP) && (tick_cnt == TW'(TICK_DIV - 1));
        play_end = (state == S_PLAY) && tick && (dur_cnt == DUR_W'(1));
        gap_end  = (state == S_GAP) && tick && (gap_cnt == GW'(1));
        advance  = (play_end && (GAP_TICKS == 0)) || gap_end;
        last     = (note_idx == IDX_W'(SONG_LEN - 1));
        finish   = advance && last && !loop_en;
        abort    = stop && (state != S_IDLE);
        state_next = state;
        case (state)
            S_IDLE: if (start && !stop) state_next = S_LOAD;
            S_LOAD: state_next = S_PLAY;
            S_PLAY: begin
                if (advance)       state_next = finish ? S_IDLE : S_LOAD;
                else if (play_end) state_next = S_GAP;
            end
            S_GAP:  if (advance) state_next = finish ? S_IDLE : S_LOAD;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_comb begin
        tone_d  = tone_cnt;
        valid_d = note_valid;
        idx_d   = note_idx;
        dur_d   = dur_cnt;
        gap_d   = gap_cnt;
        done_d  = 1'b0;
        tick_d  = tick_cnt;
        if (state == S_PLAY || state == S_GAP) tick_d = tick ? '0 : tick_cnt + TW'(1);
        case (state)
            S_IDLE: if (start && !stop) idx_d = '0;
            S_LOAD: begin
                tone_d  = pitch_div(pitch);
                valid_d = (pitch != P_REST);
                dur_d   = (dur == '0) ? DUR_W'(1) : dur;
                tick_d  = '0;
            end
            S_PLAY: begin
                if (tick) dur_d = dur_cnt - DUR_W'(1);
                if (play_end) begin
                    tone_d  = '0;
                    valid_d = 1'b0;
                    gap_d   = GW'(GAP_TICKS);
                end
            end
            S_GAP:  if (tick) gap_d = gap_cnt - GW'(1);
            default: ;
        endcase
        if (advance) begin
            idx_d  = last ? '0 : note_idx + IDX_W'(1);
            done_d = finish;
        end
        // stop overrides any same-cycle advance and suppresses done
        if (abort) begin
            tone_d  = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_piezo_note_seq.sv
// Bench for piezo_note_seq: a gapped (GAP_TICKS=1) and a gapless (GAP_TICKS=0)
// instance share stimulus and are checked every cycle against a timeline model.
module tb_piezo_note_seq;
    import piezo_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [9:0] tone_o  [2];
    logic       valid_o [2];
    logic [3:0] idx_o   [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    state_t     dbg_o   [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int song_div [8] = '{638, 638, 758, 851, 638, 638, 758, 0};
    int song_dur [8] = '{2, 2, 2, 2, 2, 2, 4, 4};
    int gap_t    [2] = '{1, 0};

    // model: per instance, whether playing, which note, cycles since its LOAD
    bit m_active [2] = '{0, 0};
    int m_idx    [2] = '{0, 0};
    int m_pos    [2] = '{0, 0};
    bit m_done   [2] = '{0, 0};

    always #5 clk = ~clk;

    piezo_note_seq #(.TICK_DIV(TD), .GAP_TICKS(1), .SONG_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .tone_cnt(tone_o[0]), .note_valid(valid_o[0]), .note_idx(idx_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .dbg_state(dbg_o[0])
    );

    piezo_note_seq #(.TICK_DIV(TD), .GAP_TICKS(0), .SONG_LEN(8)) dut_nogap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .tone_cnt(tone_o[1]), .note_valid(valid_o[1]), .note_idx(idx_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .dbg_state(dbg_o[1])
    );

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int note_period(int k, int i);
        return 1 + song_dur[i] * TD + gap_t[k] * TD;
    endfunction

    function automatic int exp_tone(int k);
        if (!m_active[k]) return 0;
        if (m_pos[k] >= 1 && m_pos[k] <= song_dur[m_idx[k]] * TD) return song_div[m_idx[k]];
        return 0;
    endfunction

    function automatic int exp_state(int k);
        if (!m_active[k]) return int'(S_IDLE);
        if (m_pos[k] == 0) return int'(S_LOAD);
        if (m_pos[k] <= song_dur[m_idx[k]] * TD) return int'(S_PLAY);
        return int'(S_GAP);
    endfunction

    task automatic model_step(int k);
        m_done[k] = 1'b0;
        if (!m_active[k]) begin
            if (start && !stop) begin
                m_active[k] = 1'b1;
                m_idx[k]    = 0;
                m_pos[k]    = 0;
            end
        end else if (stop) begin
            m_active[k] = 1'b0;
            m_idx[k]    = 0;
            m_pos[k]    = 0;
        end else begin
            m_pos[k]++;
            if (m_pos[k] == note_period(k, m_idx[k])) begin
                m_pos[k] = 0;
                if (m_idx[k] < 7) m_idx[k]++;
                else if (loop_en) m_idx[k] = 0;
                else begin
                    m_active[k] = 1'b0;
                    m_idx[k]    = 0;
                    m_done[k]   = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                m_idx[k]    = 0;
                m_pos[k]    = 0;
                m_done[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("tone[%0d]", k), int'(tone_o[k]), exp_tone(k));
                check($sformatf("valid[%0d]", k), int'(valid_o[k]), int'(exp_tone(k) != 0));
                check($sformatf("idx[%0d]", k), int'(idx_o[k]), m_active[k] ? m_idx[k] : 0);
                check($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m_active[k]));
                check($sformatf("done[%0d]", k), int'(done_o[k]), int'(m_done[k]));
                check($sformatf("state[%0d]", k), int'(dbg_o[k]), exp_state(k));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!busy_o[0] && !busy_o[1]) begin ok = 1'b1; break; end
        end
        check(name, int'(ok), 1);
    endtask

    task automatic async_reset();
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("rst_tone", int'(tone_o[0]), 0);
        check("rst_valid", int'(valid_o[0]), 0);
        check("rst_idx", int'(idx_o[0]), 0);
        check("rst_busy", int'(busy_o[0]) + int'(busy_o[1]), 0);
        check("rst_done", int'(done_o[0]), 0);
        check("rst_tone_nogap", int'(tone_o[1]), 0);
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic directed_song();
        int d0_at = 0;
        int d1_at = 0;
        loop_en = 1'b0;
        pulse_start();
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check("first_tone", int'(tone_o[0]), 638);
                check("first_valid", int'(valid_o[0]), 1);
                check("first_tone_nogap", int'(tone_o[1]), 638);
            end
            if (n == 8)  check("hold_8", int'(tone_o[0]), 638);
            if (n == 9)  check("gap_start", int'(tone_o[0]), 0);
            if (n == 13) check("load_silent", int'(tone_o[0]), 0);
            if (n == 14) check("second_note", int'(tone_o[0]), 638);
            if (n == 9)  check("nogap_load", int'(tone_o[1]), 0);
            if (n == 10) check("nogap_second", int'(tone_o[1]), 638);
            if (done_o[1] && d1_at == 0) d1_at = n;
            if (done_o[0]) begin
                d0_at = n;
                check("busy_with_done", int'(busy_o[0]), 0);
                break;
            end
        end
        check("done_latency", d0_at, 120);
        check("done_latency_nogap", d1_at, 88);
    endtask

    task automatic directed_loop();
        int  dn0 = 0;
        int  dn1 = 0;
        bit  wrapped = 1'b0;
        logic [3:0] prev = 4'd0;
        loop_en = 1'b1;
        pulse_start();
        for (int c = 0; c < 250; c++) begin
            @(posedge clk); #1;
            if (done_o[0]) dn0++;
            if (done_o[1]) dn1++;
            if (prev == 4'd7 && idx_o[0] == 4'd0 && busy_o[0]) wrapped = 1'b1;
            prev = idx_o[0];
        end
        check("loop_wrapped", int'(wrapped), 1);
        check("loop_no_done", dn0 + dn1, 0);
        @(negedge clk); loop_en = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (done_o[0]) dn0++;
            if (done_o[1]) dn1++;
            if (!busy_o[0] && !busy_o[1]) break;
        end
        check("loop_end_done", dn0, 1);
        check("loop_end_done_nogap", dn1, 1);
    endtask

    task automatic directed_stop();
        bit seen = 1'b0;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (tone_o[0] == 10'd758) begin seen = 1'b1; break; end
        end
        check("stop_reach_e", int'(seen), 1);
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1;
        check("stop_tone", int'(tone_o[0]), 0);
        check("stop_busy", int'(busy_o[0]), 0);
        check("stop_idx", int'(idx_o[0]), 0);
        check("stop_done", int'(done_o[0]), 0);
        @(negedge clk); stop = 1'b0;
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        check("start_stop_idle", int'(busy_o[0]) + int'(busy_o[1]), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy_o[0]), 0);
        check("reset_tone", int'(tone_o[0]), 0);
        check("reset_idx", int'(idx_o[0]), 0);
        chk_en = 1'b1;
        @(negedge clk); rst = 1'b1;

        directed_song();
        wait_idle("idle_after_song");
        directed_loop();
        directed_stop();
        pulse_start();
        repeat (20) @(posedge clk);
        async_reset();
        #1;
        check("post_reset_busy", int'(busy_o[0]), 0);
        check("post_reset_tone", int'(tone_o[0]), 0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pulse_start();
                4:          pulse_stop();
                5:          begin @(negedge clk); loop_en = ~loop_en; end
                6:          begin
                                @(negedge clk); start = 1'b1; stop = 1'b1;
                                @(negedge clk); start = 1'b0; stop = 1'b0;
                            end
                7:          async_reset();
                default:    begin @(negedge clk); loop_en = 1'(($urandom_range(0, 1))); end
            endcase
            repeat ($urandom_range(1, 60)) @(posedge clk);
        end

        @(negedge clk); loop_en = 1'b0;
        wait_idle("idle_at_end");
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
